// File: rtl/mem_dbus_if_pkg.sv
// Shared types and constants for the MEM-stage data-bus master.
// The optional watchdog is built when DBUS_TIMEOUT_EN is defined. Its counter
// width comes from watchdog_width().
package mem_dbus_if_pkg;

    // Bus master sequencing states, 2-bit encoded.
    typedef enum logic [1:0] {
        DBUS_IDLE       = 2'b00,
        DBUS_BUSY       = 2'b01,
        DBUS_WAIT_STALL = 2'b10
    } dbus_state_t;

    localparam int                   REG_BUS_W = 32;
    localparam logic [REG_BUS_W-1:0] ZERO_WORD = '0;

    // Position of the MEM stage in the ctrl stall vector.
    localparam int   MEM_STAGE_BIT = 4;
    localparam logic STOP          = 1'b1;
    localparam logic NO_STOP       = 1'b0;

    localparam logic WRITE_ENABLE  = 1'b1;
    localparam logic WRITE_DISABLE = 1'b0;

    // Minimum width of the BUSY watchdog counter.
    localparam int DBUS_TIMEOUT_W = 8;

    // Widen the watchdog beyond its minimum only when the limit needs it.
    function automatic int watchdog_width(input int timeout_cycles);
        int w = $clog2(timeout_cycles);
        return (w > DBUS_TIMEOUT_W) ? w : DBUS_TIMEOUT_W;
    endfunction

endpackage

// File: rtl/mem_dbus_if.sv
// MEM-stage data-bus master: turns the MEM stage's combinational load/store
// request into one registered Wishbone-style transaction. It requests a stall
// while the access is in flight. It holds the load result while the pipeline
// is frozen, so mem_wb sees the right value and a store is never reissued.
// Define DBUS_TIMEOUT_EN to add a BUSY watchdog that aborts after
// TIMEOUT_CYCLES cycles without an acknowledge.
module mem_dbus_if
    import mem_dbus_if_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [5:0]           stall,
    input  logic                 flush,
    input  logic                 cpu_ce_i,
    input  logic                 cpu_we_i,
    input  logic [REG_BUS_W-1:0] cpu_addr_i,
    input  logic [3:0]           cpu_sel_i,
    input  logic [REG_BUS_W-1:0] cpu_data_i,
    output logic [REG_BUS_W-1:0] cpu_data_o,
    output logic                 stallreq_o,
    output logic                 bus_cyc_o,
    output logic                 bus_stb_o,
    output logic                 bus_we_o,
    output logic [REG_BUS_W-1:0] bus_adr_o,
    output logic [3:0]           bus_sel_o,
    output logic [REG_BUS_W-1:0] bus_dat_o,
    input  logic [REG_BUS_W-1:0] bus_dat_i,
    input  logic                 bus_ack_i,
    output logic                 bus_timeout_o
);

    // A limit below 2 would abort in the issue cycle's shadow; reject it.
    if (TIMEOUT_CYCLES < 2) begin : g_timeout_param_check
        $error("mem_dbus_if: TIMEOUT_CYCLES must be at least 2");
    end

    dbus_state_t          state_q, state_d;
    logic [REG_BUS_W-1:0] rd_buf_q, rd_buf_d;

    logic mem_held;      // MEM stage frozen by ctrl this cycle
    logic issue;         // launch a new bus cycle at the next edge
    logic retire;        // ack (or watchdog abort) ends the cycle at the next edge
    logic drop;          // flush kills whatever is on the bus
    logic timeout_hit;   // watchdog limit reached in BUSY without ack

    // Only the MEM-stage bit of the stall vector matters here.
    logic unused_stall_bits;
    assign unused_stall_bits = ^{stall[5], stall[3:0]};

    assign mem_held = (stall[MEM_STAGE_BIT] == STOP);

`ifdef DBUS_TIMEOUT_EN
    localparam int                  WDOG_W    = watchdog_width(TIMEOUT_CYCLES);
    localparam logic [WDOG_W-1:0]   WDOG_LAST = WDOG_W'(TIMEOUT_CYCLES - 1);

    logic [WDOG_W-1:0] wdog_q;

    // Watchdog: restart on every issue, count BUSY cycles that go unanswered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wdog_q <= '0;
        end else if (issue) begin
            wdog_q <= '0;
        end else if (state_q == DBUS_BUSY && !bus_ack_i && !flush) begin
            wdog_q <= wdog_q + 1'b1;
        end
    end

    assign timeout_hit = (state_q == DBUS_BUSY) && !bus_ack_i && (wdog_q == WDOG_LAST);
`else
    assign timeout_hit = 1'b0;
`endif

    // State register and read-data buffer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: sequential state uses <= so every flop samples pre-edge values.
            state_q  <= DBUS_IDLE;
            rd_buf_q <= ZERO_WORD;
        end else begin
            state_q  <= state_d;
            rd_buf_q <= rd_buf_d;
        end
    end

    // Next state, read-buffer update and the combinational cpu-side outputs.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        state_d       = state_q;
        rd_buf_d      = rd_buf_q;
        issue         = 1'b0;
        retire        = 1'b0;
        drop          = 1'b0;
        cpu_data_o    = ZERO_WORD;
        stallreq_o    = 1'b0;
        bus_timeout_o = 1'b0;

        if (!rst) begin
            if (flush) begin
                // Flush wins over everything, including a same-cycle ack.
                drop     = 1'b1;
                rd_buf_d = ZERO_WORD;
                state_d  = DBUS_IDLE;
            end else begin
                unique case (state_q)
                    DBUS_IDLE: begin
                        if (cpu_ce_i) begin
                            issue      = 1'b1;
                            stallreq_o = 1'b1;
                            state_d    = DBUS_BUSY;
                        end
                    end

                    DBUS_BUSY: begin
                        if (bus_ack_i) begin
                            retire     = 1'b1;
                            rd_buf_d   = (bus_we_o == WRITE_ENABLE) ? ZERO_WORD : bus_dat_i;
                            cpu_data_o = (bus_we_o == WRITE_ENABLE) ? ZERO_WORD : bus_dat_i;
                            state_d    = mem_held ? DBUS_WAIT_STALL : DBUS_IDLE;
                        end else if (timeout_hit) begin
                            // Abort behaves like an ack carrying zero data.
                            retire        = 1'b1;
                            rd_buf_d      = ZERO_WORD;
                            bus_timeout_o = 1'b1;
                            state_d       = mem_held ? DBUS_WAIT_STALL : DBUS_IDLE;
                        end else begin
                            stallreq_o = 1'b1;
                        end
                    end

                    DBUS_WAIT_STALL: begin
                        // Instruction still parked in MEM: replay the captured
                        // result and keep ce from launching a duplicate access.
                        cpu_data_o = rd_buf_q;
                        if (stall[MEM_STAGE_BIT] == NO_STOP) begin
                            state_d = DBUS_IDLE;
                        end
                    end

                    default: begin
                        state_d = DBUS_IDLE;
                    end
                endcase
            end
        end
    end

    // Registered bus outputs; address and data simply hold after the cycle ends.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus_cyc_o <= 1'b0;
            bus_stb_o <= 1'b0;
            bus_we_o  <= WRITE_DISABLE;
            bus_adr_o <= ZERO_WORD;
            bus_sel_o <= 4'b0000;
            bus_dat_o <= ZERO_WORD;
        end else if (drop || retire) begin
            bus_cyc_o <= 1'b0;
            bus_stb_o <= 1'b0;
            bus_we_o  <= WRITE_DISABLE;
            bus_sel_o <= 4'b0000;
        end else if (issue) begin
            bus_cyc_o <= 1'b1;
            bus_stb_o <= 1'b1;
            bus_we_o  <= cpu_we_i;
            bus_adr_o <= cpu_addr_i;
            bus_sel_o <= cpu_sel_i;
            bus_dat_o <= cpu_data_i;
        end
    end

endmodule

// File: tb/tb_mem_dbus_if.sv
// Directed bench for mem_dbus_if. Bus transactions and load results expected
// from each request go into queues when the request is driven. They are popped
// and compared when the DUT puts the cycle on the bus or completes it.
// Build with DBUS_TIMEOUT_EN to exercise the watchdog abort.
module tb_mem_dbus_if;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall;
    logic        flush;
    logic        cpu_ce_i;
    logic        cpu_we_i;
    logic [31:0] cpu_addr_i;
    logic [3:0]  cpu_sel_i;
    logic [31:0] cpu_data_i;
    logic [31:0] cpu_data_o;
    logic        stallreq_o;
    logic        bus_cyc_o;
    logic        bus_stb_o;
    logic        bus_we_o;
    logic [31:0] bus_adr_o;
    logic [3:0]  bus_sel_o;
    logic [31:0] bus_dat_o;
    logic [31:0] bus_dat_i;
    logic        bus_ack_i;
    logic        bus_timeout_o;

    mem_dbus_if #(.TIMEOUT_CYCLES(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .flush         (flush),
        .cpu_ce_i      (cpu_ce_i),
        .cpu_we_i      (cpu_we_i),
        .cpu_addr_i    (cpu_addr_i),
        .cpu_sel_i     (cpu_sel_i),
        .cpu_data_i    (cpu_data_i),
        .cpu_data_o    (cpu_data_o),
        .stallreq_o    (stallreq_o),
        .bus_cyc_o     (bus_cyc_o),
        .bus_stb_o     (bus_stb_o),
        .bus_we_o      (bus_we_o),
        .bus_adr_o     (bus_adr_o),
        .bus_sel_o     (bus_sel_o),
        .bus_dat_o     (bus_dat_o),
        .bus_dat_i     (bus_dat_i),
        .bus_ack_i     (bus_ack_i),
        .bus_timeout_o (bus_timeout_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [3:0]  sel;
        logic [31:0] dat;
    } txn_t;

    txn_t        exp_bus[$];
    logic [31:0] exp_rd[$];
    txn_t        cur;

    int total = 0;
    int bad   = 0;
    int nstall;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request and record what it should produce.
    task automatic drive_req(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                             input logic [31:0] dat, input logic [31:0] rd_exp);
        txn_t t;
        cpu_ce_i   = 1'b1;
        cpu_we_i   = we;
        cpu_addr_i = adr;
        cpu_sel_i  = sel;
        cpu_data_i = dat;
        t.we  = we;
        t.adr = adr;
        t.sel = sel;
        t.dat = dat;
        exp_bus.push_back(t);
        exp_rd.push_back(rd_exp);
    endtask

    // Compare the live bus against the transaction currently held in cur.
    task automatic check_bus_hold(input string tag);
        check({tag, "_cyc"}, 32'(bus_cyc_o), 32'd1);
        check({tag, "_stb"}, 32'(bus_stb_o), 32'd1);
        check({tag, "_we"},  32'(bus_we_o),  32'(cur.we));
        check({tag, "_adr"}, bus_adr_o,      cur.adr);
        check({tag, "_sel"}, 32'(bus_sel_o), 32'(cur.sel));
        if (cur.we) check({tag, "_dat"}, bus_dat_o, cur.dat);
    endtask

    // First BUSY cycle: pop the expected transaction and compare.
    task automatic check_bus(input string tag);
        if (exp_bus.size() == 0) begin
            check({tag, "_sb_underflow"}, 32'd1, 32'd0);
        end else begin
            cur = exp_bus.pop_front();
            check_bus_hold(tag);
        end
    endtask

    // Completion cycle: pop the expected load result, stall must be released.
    task automatic check_done(input string tag);
        logic [31:0] e;
        if (exp_rd.size() == 0) begin
            check({tag, "_rd_underflow"}, 32'd1, 32'd0);
        end else begin
            e = exp_rd.pop_front();
            check({tag, "_rdata"}, cpu_data_o, e);
        end
        check({tag, "_stallreq"}, 32'(stallreq_o), 32'd0);
    endtask

    // Backstop in case the run never reaches its summary.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        rst        = 1'b0;
        stall      = 6'b000000;
        flush      = 1'b0;
        cpu_ce_i   = 1'b1;
        cpu_we_i   = 1'b0;
        cpu_addr_i = 32'h0000_0FF0;
        cpu_sel_i  = 4'hF;
        cpu_data_i = 32'h0000_0001;
        bus_dat_i  = 32'h0;
        bus_ack_i  = 1'b0;
        #1 rst = 1'b1;
        #1;

        // ---- reset state (ce held high to show it cannot leak through) ----
        check("rst_stallreq", 32'(stallreq_o), 32'd0);
        check("rst_cyc",      32'(bus_cyc_o),  32'd0);
        check("rst_stb",      32'(bus_stb_o),  32'd0);
        check("rst_we",       32'(bus_we_o),   32'd0);
        check("rst_adr",      bus_adr_o,       32'd0);
        check("rst_sel",      32'(bus_sel_o),  32'd0);
        check("rst_dat",      bus_dat_o,       32'd0);
        check("rst_rdata",    cpu_data_o,      32'd0);
        check("rst_timeout",  32'(bus_timeout_o), 32'd0);
        tick();
        check("rst_hold_cyc", 32'(bus_cyc_o), 32'd0);
        rst      = 1'b0;
        cpu_ce_i = 1'b0;
        tick();

        // ---- load, zero wait states ----
        drive_req(1'b0, 32'h0000_0100, 4'hF, 32'h0, 32'hDEAD_BEEF);
        #1;
        check("ld0_issue_stallreq", 32'(stallreq_o), 32'd1);
        check("ld0_issue_no_comb",  32'(bus_cyc_o),  32'd0);
        tick();
        check_bus("ld0_busy");
        bus_ack_i = 1'b1;
        bus_dat_i = 32'hDEAD_BEEF;
        #1;
        check_done("ld0_ack");
        tick();
        // Stray ack while IDLE must be ignored.
        cpu_ce_i  = 1'b0;
        bus_dat_i = 32'h7777_7777;
        #1;
        check("ld0_idle_cyc",      32'(bus_cyc_o),  32'd0);
        check("ld0_idle_rdata",    cpu_data_o,      32'd0);
        check("ld0_idle_stallreq", 32'(stallreq_o), 32'd0);
        bus_ack_i = 1'b0;
        tick();

        // ---- store, 3 wait states (ack in 4th BUSY cycle) ----
        nstall = 0;
        drive_req(1'b1, 32'h0000_0204, 4'b0011, 32'h1234_5678, 32'h0);
        #1;
        if (stallreq_o) nstall++;
        tick();
        for (int w = 0; w < 3; w++) begin
            if (w == 0) check_bus("st_busy");
            else        check_bus_hold("st_hold");
            #1;
            if (stallreq_o) nstall++;
            check("st_wait_rdata", cpu_data_o, 32'd0);
            tick();
        end
        check_bus_hold("st_last");
        bus_ack_i = 1'b1;
        bus_dat_i = 32'hA5A5_A5A5;
        #1;
        if (stallreq_o) nstall++;
        check_done("st_ack");
        // Issue cycle plus three unanswered BUSY cycles.
        check("st_stallreq_cycles", 32'(nstall), 32'd4);
        tick();
        cpu_ce_i  = 1'b0;
        bus_ack_i = 1'b0;
        #1;
        check("st_end_cyc",      32'(bus_cyc_o),  32'd0);
        check("st_end_stb",      32'(bus_stb_o),  32'd0);
        check("st_end_we",       32'(bus_we_o),   32'd0);
        check("st_end_sel",      32'(bus_sel_o),  32'd0);
        check("st_end_stallreq", 32'(stallreq_o), 32'd0);
        tick();

        // ---- load acked while MEM is held: WAIT_STALL replay ----
        drive_req(1'b0, 32'h0000_0300, 4'hF, 32'h0, 32'hCAFE_F00D);
        #1;
        check("ws_issue_stallreq", 32'(stallreq_o), 32'd1);
        tick();
        check_bus("ws_busy");
        stall     = 6'b011111;
        bus_ack_i = 1'b1;
        bus_dat_i = 32'hCAFE_F00D;
        #1;
        check_done("ws_ack");
        tick();
        bus_ack_i = 1'b0;
        bus_dat_i = 32'h1111_1111;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("ws_hold_rdata",    cpu_data_o,      32'hCAFE_F00D);
            check("ws_hold_cyc",      32'(bus_cyc_o),  32'd0);
            check("ws_hold_stallreq", 32'(stallreq_o), 32'd0);
            tick();
        end
        stall    = 6'b000000;
        cpu_ce_i = 1'b0;
        #1;
        check("ws_release_rdata", cpu_data_o, 32'hCAFE_F00D);
        tick();
        check("ws_idle_rdata", cpu_data_o,     32'd0);
        check("ws_idle_cyc",   32'(bus_cyc_o), 32'd0);

        // ---- flush in 2nd BUSY cycle with a simultaneous ack ----
        drive_req(1'b0, 32'h0000_0400, 4'hF, 32'h0, 32'h0);
        #1;
        check("fl_issue_stallreq", 32'(stallreq_o), 32'd1);
        tick();
        check_bus("fl_busy");
        #1;
        check("fl_busy1_stallreq", 32'(stallreq_o), 32'd1);
        tick();
        flush     = 1'b1;
        bus_ack_i = 1'b1;
        bus_dat_i = 32'h55AA_55AA;
        #1;
        check_done("fl_flush");
        tick();
        flush     = 1'b0;
        bus_ack_i = 1'b0;
        cpu_ce_i  = 1'b0;
        #1;
        check("fl_after_cyc",      32'(bus_cyc_o),  32'd0);
        check("fl_after_stb",      32'(bus_stb_o),  32'd0);
        check("fl_after_stallreq", 32'(stallreq_o), 32'd0);
        check("fl_after_rdata",    cpu_data_o,      32'd0);
        tick();

        // ---- async reset between edges while BUSY ----
        drive_req(1'b1, 32'h0000_0500, 4'hF, 32'h0BAD_F00D, 32'h0);
        #1;
        tick();
        check_bus("ar_busy");
        #2 rst = 1'b1;
        #1;
        check("ar_cyc",      32'(bus_cyc_o),  32'd0);
        check("ar_stb",      32'(bus_stb_o),  32'd0);
        check("ar_we",       32'(bus_we_o),   32'd0);
        check("ar_adr",      bus_adr_o,       32'd0);
        check("ar_sel",      32'(bus_sel_o),  32'd0);
        check("ar_dat",      bus_dat_o,       32'd0);
        check_done("ar_rst");
        #1;
        rst      = 1'b0;
        cpu_ce_i = 1'b0;
        tick();
        check("ar_post_cyc", 32'(bus_cyc_o), 32'd0);
        drive_req(1'b0, 32'h0000_0600, 4'hF, 32'h0, 32'h600D_CAFE);
        #1;
        check("ar_reissue_stallreq", 32'(stallreq_o), 32'd1);
        tick();
        check_bus("ar_reissue");
        bus_ack_i = 1'b1;
        bus_dat_i = 32'h600D_CAFE;
        #1;
        check_done("ar_reissue_ack");
        tick();
        cpu_ce_i  = 1'b0;
        bus_ack_i = 1'b0;
        #1;
        check("ar_reissue_end_cyc", 32'(bus_cyc_o), 32'd0);
        tick();

`ifdef DBUS_TIMEOUT_EN
        // ---- watchdog: slave never acks, limit 8 ----
        drive_req(1'b0, 32'h0000_0700, 4'hF, 32'h0, 32'h0);
        #1;
        tick();
        check_bus("to_busy");
        for (int k = 1; k <= 7; k++) begin
            #1;
            check("to_wait_pulse",    32'(bus_timeout_o), 32'd0);
            check("to_wait_stallreq", 32'(stallreq_o),    32'd1);
            tick();
        end
        cpu_ce_i = 1'b0;
        #1;
        check("to_pulse", 32'(bus_timeout_o), 32'd1);
        check_done("to_abort");
        tick();
        #1;
        check("to_after_cyc",   32'(bus_cyc_o),     32'd0);
        check("to_after_pulse", 32'(bus_timeout_o), 32'd0);
        tick();
`else
        // ---- no watchdog: BUSY waits indefinitely ----
        drive_req(1'b0, 32'h0000_0700, 4'hF, 32'h0, 32'h0F0F_0F0F);
        #1;
        tick();
        check_bus("nt_busy");
        for (int k = 0; k < 20; k++) begin
            #1;
            check("nt_wait_pulse",    32'(bus_timeout_o), 32'd0);
            check("nt_wait_stallreq", 32'(stallreq_o),    32'd1);
            tick();
        end
        check_bus_hold("nt_hold");
        bus_ack_i = 1'b1;
        bus_dat_i = 32'h0F0F_0F0F;
        #1;
        check_done("nt_ack");
        tick();
        cpu_ce_i  = 1'b0;
        bus_ack_i = 1'b0;
        #1;
        check("nt_end_cyc", 32'(bus_cyc_o), 32'd0);
        tick();
`endif

        check("sb_bus_empty", 32'(exp_bus.size()), 32'd0);
        check("sb_rd_empty",  32'(exp_rd.size()),  32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
